// File: rtl/rvv_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rvv_cfg_pkg
//  Purpose  : Shared RVV configuration types and encoding constants used by
//             the vector issue stage and its helpers.
//  Contents : sew_e, lmul_e, agnostic_e, vtype_t, vcfg_t, opcode/funct3
//             constants, vtype_illegal() helper.
//  Revision : 1.0  initial release
// ============================================================================
package rvv_cfg_pkg;

    // vcfg_t is sized for the default build (VLEN=128).
    localparam int CFG_VLEN = 128;
    localparam int CFG_VLW  = $clog2(CFG_VLEN) + 1;

    localparam logic [6:0] OPC_LD    = 7'b0000111;
    localparam logic [6:0] OPC_ST    = 7'b0100111;
    localparam logic [6:0] OPC_ALU   = 7'b1010111;
    localparam logic [2:0] F3_OPCFG  = 3'b111;

    typedef enum logic [2:0] {
        SEW8  = 3'd0,
        SEW16 = 3'd1,
        SEW32 = 3'd2,
        SEW64 = 3'd3
    } sew_e;

    typedef enum logic [2:0] {
        LMUL1     = 3'd0,
        LMUL2     = 3'd1,
        LMUL4     = 3'd2,
        LMUL8     = 3'd3,
        LMUL_LAST = 3'd4,
        LMUL1_8   = 3'd5,
        LMUL1_4   = 3'd6,
        LMUL1_2   = 3'd7
    } lmul_e;

    typedef enum logic {
        UNDISTURBED = 1'b0,
        AGNOSTIC    = 1'b1
    } agnostic_e;

    typedef struct packed {
        logic        vill;
        logic [22:0] rsvd;
        agnostic_e   vma;
        agnostic_e   vta;
        sew_e        vsew;
        lmul_e       vlmul;
    } vtype_t;

    typedef struct packed {
        vtype_t               vtype;
        logic [CFG_VLW-1:0]   vl;
    } vcfg_t;

    function automatic vtype_t vtype_illegal();
        vtype_t v;
        v      = '0;
        v.vill = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvv_vlmax_calc.sv
`default_nettype none
// ============================================================================
//  Module   : rvv_vlmax_calc
//  Purpose  : Combinational VLMAX and SEW/LMUL legality for a vtype.
//  Ports    : vsew, vlmul  -> requested element width / group multiplier
//             vlmax        -> (VLEN/SEW)*LMUL, 0 when illegal
//             legal        -> SEW supported and SEW/LMUL pair allowed
//  Revision : 1.0  initial release
// ============================================================================
module rvv_vlmax_calc
    import rvv_cfg_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int VLW  = $clog2(VLEN) + 1
) (
    input  sew_e             vsew,
    input  lmul_e            vlmul,
    output logic [VLW-1:0]   vlmax,
    output logic             legal
);

    localparam logic [VLW-1:0] C_ELEMS_SEW8 = VLW'(VLEN / 8);

    logic [2:0]     w_sew_code;
    logic [VLW-1:0] w_per_reg;
    logic [VLW-1:0] w_scaled;
    logic           w_sew_ok;
    logic           w_ratio_ok;

    always_comb begin
        w_sew_code = vsew;
        // Elements per single register; only meaningful for SEW8..SEW32.
        w_per_reg  = C_ELEMS_SEW8 >> w_sew_code[1:0];
        w_sew_ok   = (vsew == SEW8) || (vsew == SEW16) || (vsew == SEW32);
        w_ratio_ok = 1'b0;
        w_scaled   = '0;
        // Fractional LMUL is only allowed while SEW/LMUL stays <= 32, so the
        // right shifts below are always exact.
        case (vlmul)
            LMUL1:   begin w_ratio_ok = 1'b1; w_scaled = w_per_reg;       end
            LMUL2:   begin w_ratio_ok = 1'b1; w_scaled = w_per_reg << 1;  end
            LMUL4:   begin w_ratio_ok = 1'b1; w_scaled = w_per_reg << 2;  end
            LMUL8:   begin w_ratio_ok = 1'b1; w_scaled = w_per_reg << 3;  end
            LMUL1_2: begin
                w_ratio_ok = (vsew == SEW8) || (vsew == SEW16);
                w_scaled   = w_per_reg >> 1;
            end
            LMUL1_4: begin
                w_ratio_ok = (vsew == SEW8);
                w_scaled   = w_per_reg >> 2;
            end
            default: begin w_ratio_ok = 1'b0; w_scaled = '0; end
        endcase
        legal = w_sew_ok && w_ratio_ok;
        vlmax = legal ? w_scaled : '0;
    end

endmodule
`default_nettype wire

// File: rtl/rvv_vcfg_issue.sv
`default_nettype none
// ============================================================================
//  Module   : rvv_vcfg_issue
//  Purpose  : RVV issue stage in front of the vector backend. Executes
//             vsetvli/vsetivli/vsetvl locally, holds architectural vtype/vl,
//             and forwards vector LD/ST/ALU ops tagged with the config
//             snapshot in force at accept time.
//  Ports    : inst_*  upstream instruction + scalar operands (valid/ready)
//             uop_*   forwarded op + vtype/vl snapshot (valid/ready)
//             xwb_*   one-cycle vl writeback to scalar rd
//             illegal one-cycle pulse when a vector op is dropped (vill=1)
//  Revision : 1.0  initial release
// ============================================================================
module rvv_vcfg_issue
    import rvv_cfg_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int XLEN = 32,
    parameter int VLW  = $clog2(VLEN) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [31:0]      inst_bits,
    input  logic [XLEN-1:0]  inst_rs1,
    input  logic [XLEN-1:0]  inst_rs2,
    output logic             uop_valid,
    input  logic             uop_ready,
    output logic [31:0]      uop_bits,
    output logic [XLEN-1:0]  uop_rs1,
    output logic [31:0]      uop_vtype,
    output logic [VLW-1:0]   uop_vl,
    output logic             xwb_valid,
    output logic [4:0]       xwb_idx,
    output logic [XLEN-1:0]  xwb_data,
    output logic             illegal
);

    // ---------------------------------------------------------------- decode
    logic [6:0]     w_opcode;
    logic [2:0]     w_funct3;
    logic [4:0]     w_rd;
    logic [4:0]     w_rs1_idx;
    logic           w_is_vset;
    logic           w_is_vop;
    logic           w_is_ivli;
    logic [31:0]    w_raw_vtype;
    vtype_t         w_req_vtype;
    logic [VLW-1:0] w_vlmax;
    logic           w_calc_legal;
    logic           w_vtype_ok;
    logic           w_keep_vl;
    logic           w_new_ok;
    logic [XLEN-1:0] w_avl;
    logic [VLW-1:0] w_new_vl;
    vtype_t         w_new_vtype;
    logic           w_accept;
    logic           w_load;

    vtype_t          r_vtype;
    logic [VLW-1:0]  r_vl;
    logic            r_uop_valid;
    logic [31:0]     r_uop_bits;
    logic [XLEN-1:0] r_uop_rs1;
    vtype_t          r_uop_vtype;
    logic [VLW-1:0]  r_uop_vl;
    logic            r_xwb_valid;
    logic [4:0]      r_xwb_idx;
    logic [XLEN-1:0] r_xwb_data;
    logic            r_illegal;

    assign w_opcode  = inst_bits[6:0];
    assign w_funct3  = inst_bits[14:12];
    assign w_rd      = inst_bits[11:7];
    assign w_rs1_idx = inst_bits[19:15];
    assign w_is_vset = (w_opcode == OPC_ALU) && (w_funct3 == F3_OPCFG);
    assign w_is_vop  = !w_is_vset &&
                       ((w_opcode == OPC_LD) || (w_opcode == OPC_ST) || (w_opcode == OPC_ALU));
    assign w_is_ivli = (inst_bits[31:30] == 2'b11);

    always_comb begin
        if (!inst_bits[31])
            w_raw_vtype = {21'd0, inst_bits[30:20]};
        else if (w_is_ivli)
            w_raw_vtype = {22'd0, inst_bits[29:20]};
        else if (inst_bits[31:25] == 7'b1000000)
            w_raw_vtype = inst_rs2[31:0];
        else
            w_raw_vtype = 32'h8000_0000;   // unknown vset form: force vill
    end

    assign w_req_vtype = vtype_t'(w_raw_vtype);

    rvv_vlmax_calc #(
        .VLEN (VLEN),
        .VLW  (VLW)
    ) u_vlmax (
        .vsew  (w_req_vtype.vsew),
        .vlmul (w_req_vtype.vlmul),
        .vlmax (w_vlmax),
        .legal (w_calc_legal)
    );

    assign w_vtype_ok = w_calc_legal && !w_req_vtype.vill && (w_req_vtype.rsvd == '0);
    // rs1=x0, rd=x0 keeps the current vl; it must still fit the new VLMAX.
    assign w_keep_vl  = !w_is_ivli && (w_rs1_idx == 5'd0) && (w_rd == 5'd0);
    assign w_new_ok   = w_vtype_ok && !(w_keep_vl && (r_vl > w_vlmax));

    always_comb begin
        if (w_is_ivli)
            w_avl = XLEN'(w_rs1_idx);
        else if (w_rs1_idx != 5'd0)
            w_avl = inst_rs1;
        else if (w_rd != 5'd0)
            w_avl = XLEN'(w_vlmax);
        else
            w_avl = XLEN'(r_vl);
    end

    always_comb begin
        w_new_vl    = '0;
        w_new_vtype = vtype_illegal();
        if (w_new_ok) begin
            w_new_vtype = w_req_vtype;
            w_new_vl    = (w_avl > XLEN'(w_vlmax)) ? w_vlmax : w_avl[VLW-1:0];
        end
    end

    // Only vector ops need the output register; vset and unrecognised
    // opcodes are always taken (the latter are simply discarded).
    assign inst_ready = w_is_vop ? (!r_uop_valid || uop_ready) : 1'b1;
    assign w_accept   = inst_valid && inst_ready;
    assign w_load     = w_accept && w_is_vop && !r_vtype.vill;

    // ------------------------------------------------------ config registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vtype <= vtype_illegal();
            r_vl    <= '0;
        end else if (w_accept && w_is_vset) begin
            r_vtype <= w_new_vtype;
            r_vl    <= w_new_vl;
        end
    end

    // ------------------------------------------------------- output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_uop_valid <= 1'b0;
            r_uop_bits  <= '0;
            r_uop_rs1   <= '0;
            r_uop_vtype <= '0;
            r_uop_vl    <= '0;
        end else if (w_load) begin
            r_uop_valid <= 1'b1;
            r_uop_bits  <= inst_bits;
            r_uop_rs1   <= inst_rs1;
            r_uop_vtype <= r_vtype;
            r_uop_vl    <= r_vl;
        end else if (uop_ready) begin
            r_uop_valid <= 1'b0;
        end
    end

    // -------------------------------------------------------- pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xwb_valid <= 1'b0;
            r_xwb_idx   <= '0;
            r_xwb_data  <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_xwb_valid <= w_accept && w_is_vset;
            r_illegal   <= w_accept && w_is_vop && r_vtype.vill;
            if (w_accept && w_is_vset) begin
                r_xwb_idx  <= w_rd;
                r_xwb_data <= XLEN'(w_new_vl);
            end
        end
    end

    assign uop_valid = r_uop_valid;
    assign uop_bits  = r_uop_bits;
    assign uop_rs1   = r_uop_rs1;
    assign uop_vtype = r_uop_vtype;
    assign uop_vl    = r_uop_vl;
    assign xwb_valid = r_xwb_valid;
    assign xwb_idx   = r_xwb_idx;
    assign xwb_data  = r_xwb_data;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire
